// File: rtl/leb128_pkg.sv
// Shared definitions for the LEB128 encoder and decoder blocks.
package leb128_pkg;

  // Controller states common to the streaming encoder and decoder.
  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  // Maximum number of LEB128 bytes needed for a w-bit value: ceil(w/7).
  function automatic int leb128_nbytes(input int w);
    return (w + 6) / 7;
  endfunction

endpackage

// File: rtl/leb128_len.sv
// Combinational LEB128 length calculator: number of bytes a value encodes to.
module leb128_len
  import leb128_pkg::*;
#(
  parameter  int W      = 32,
  parameter  bit SIGNED = 1'b0,
  localparam int NB     = leb128_nbytes(W),
  localparam int LW     = $clog2(NB + 1)
) (
  input  logic [W-1:0]  value,
  output logic [LW-1:0] len
);

  localparam int EW = NB * 7;

  logic          sign;
  logic [EW-1:0] ext;

  // Extend the value to a whole number of 7-bit chunks, then find the byte count.
  always_comb begin
    // NOTE: len is given a default before the loops so no latch is inferred.
    len  = LW'(1);
    sign = SIGNED ? value[W-1] : 1'b0;
    ext  = {EW{sign}};
    ext[W-1:0] = value;
    if (SIGNED) begin
      // Smallest k whose bits [EW-1 : 7k-1] are all copies of the sign bit.
      // The property is monotonic in k, so the last hit of a descending scan wins.
      len = LW'(NB);
      for (int k = NB - 1; k >= 1; k--) begin
        if ((ext >> (7 * k - 1)) == ({EW{sign}} >> (7 * k - 1))) begin
          len = LW'(k);
        end
      end
    end else begin
      // Highest nonzero chunk index + 1, at least one byte.
      for (int i = 1; i < NB; i++) begin
        if (ext[7*i +: 7] != 7'd0) begin
          len = LW'(i + 1);
        end
      end
    end
  end

endmodule

// File: rtl/leb128_enc_stream.sv
// Streaming LEB128 encoder: one W-bit value in, its byte string out one byte per cycle.
module leb128_enc_stream
  import leb128_pkg::*;
#(
  parameter  int W      = 32,
  parameter  bit SIGNED = 1'b0,
  localparam int NB     = leb128_nbytes(W),
  localparam int LW     = $clog2(NB + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [LW-1:0] out_len
);

  localparam int EW = NB * 7;

  state_t        state;
  logic [EW-1:0] sreg;
  logic [LW-1:0] idx;
  logic [EW-1:0] in_ext;
  logic [LW-1:0] in_len;
  logic          accept;
  logic          advance;
  logic [LW:0]   next_pos;
  logic          last_next;

  leb128_len #(
    .W      (W),
    .SIGNED (SIGNED)
  ) u_len (
    .value (in_data),
    .len   (in_len)
  );

  // Sign- or zero-extend the incoming value to whole 7-bit chunks.
  always_comb begin
    in_ext = {EW{SIGNED ? in_data[W-1] : 1'b0}};
    in_ext[W-1:0] = in_data;
  end

  // A new value is taken when idle or on the final-byte handshake (no bubble).
  assign in_ready  = (state == IDLE) | ((state == EMIT) & out_valid & out_ready & out_last);
  assign accept    = in_valid & in_ready;
  assign advance   = out_valid & out_ready & ~out_last;
  // Byte position after the advance is idx+1; it is the last one when idx+2 == len.
  assign next_pos  = {1'b0, idx} + (LW + 1)'(2);
  assign last_next = (next_pos == {1'b0, out_len});

  // Encoder FSM with registered byte, last flag and length outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 8'h00;
      out_len   <= '0;
    end else if (accept) begin
      state     <= EMIT;
      sreg      <= in_ext >> 7;
      idx       <= '0;
      out_valid <= 1'b1;
      out_data  <= {in_len != LW'(1), in_ext[6:0]};
      out_last  <= (in_len == LW'(1));
      out_len   <= in_len;
    end else if (advance) begin
      sreg     <= sreg >> 7;
      idx      <= idx + LW'(1);
      out_data <= {~last_next, sreg[6:0]};
      out_last <= last_next;
    end else if (out_valid && out_ready) begin
      // Final byte taken with no follow-on value.
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
